// File: rtl/input_flit_buffer.sv
// Per-input-port flit FIFO feeding route computation: registered output,
// one credit pulse back upstream for each slot freed, sticky drop flag.
module input_flit_buffer #(
    parameter int         FlitChildWidth = 85,
    parameter int         ValidBitPos    = 81,
    parameter int         DEPTH          = 8,
    parameter int         PTR_W          = 3,
    parameter logic [2:0] PORT_DIR       = 3'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FlitChildWidth-1:0] flit_in,
    input  logic                      flit_in_valid,
    input  logic                      stall,
    output logic [FlitChildWidth-1:0] flit_out,
    output logic                      flit_valid_out,
    output logic [2:0]                dir_out,
    output logic                      credit_out,
    output logic [PTR_W:0]            occupancy,
    output logic                      overflow_err
);

    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    // The in-band valid bit is carried through untouched; only its position is sanity-checked.
    if (ValidBitPos >= FlitChildWidth || DEPTH < 2 || DEPTH != (1 << PTR_W)) begin : g_param_err
        $error("input_flit_buffer: inconsistent parameters");
    end

    logic [FlitChildWidth-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]            count_q, count_d;
    logic [FlitChildWidth-1:0] flit_out_q, flit_out_d;
    logic                      flit_valid_q, flit_valid_d;
    logic                      credit_q, credit_d;
    logic                      overflow_q, overflow_d;

    logic empty, full, pop, push;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DEPTH_CNT);
        pop   = ~empty & ~stall;
        // A full buffer still accepts a write when the head slot is leaving this cycle.
        push  = flit_in_valid & (~full | pop);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        flit_out_d   = flit_out_q;
        flit_valid_d = 1'b0;
        credit_d     = 1'b0;
        overflow_d   = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            flit_out_d   = mem_q[rd_ptr_q];
            flit_valid_d = 1'b1;
            credit_d     = 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
        if (flit_in_valid && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flit_out_q   <= '0;
            flit_valid_q <= 1'b0;
            credit_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flit_out_q   <= flit_out_d;
            flit_valid_q <= flit_valid_d;
            credit_q     <= credit_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= flit_in;
        end
    end

    assign flit_out       = flit_out_q;
    assign flit_valid_out = flit_valid_q;
    assign credit_out     = credit_q;
    assign occupancy      = count_q;
    assign overflow_err   = overflow_q;
    assign dir_out        = PORT_DIR;

endmodule

// File: doc/input_flit_buffer.md
Name: input_flit_buffer

Overview:
- Per-input-port flit FIFO sitting directly upstream of the route computation stage in each router.
- Absorbs flits arriving from a neighbouring router link or from the local injection port. Presents them one per cycle to route computation together with the fixed arrival-direction tag.
- Returns a one-cycle credit pulse to the upstream sender for every slot freed.
- A downstream stall holds flits in the buffer.

Parameters:
- FlitChildWidth, 85, width of a stored flit: 82-bit flit (valid bit at 81) plus 3-bit children field.
- ValidBitPos, 81, bit position of the in-band flit valid bit.
- DEPTH, 8, number of flit slots; must be a power of two, minimum 2.
- PTR_W, 3, log2(DEPTH).
- PORT_DIR, 3'd0, direction code of this input: 0 inject, 1 xpos, 2 ypos, 3 zpos, 4 xneg, 5 yneg, 6 zneg.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flit_in  input  FlitChildWidth  flit from upstream link or injection.
- flit_in_valid  input  1  write strobe for flit_in.
- stall  input  1  downstream cannot accept a flit this cycle.
- flit_out  output  FlitChildWidth  registered flit to route computation (flit_before_RC).
- flit_valid_out  output  1  flit_out valid this cycle (flit_valid_in of the next stage).
- dir_out  output  3  constant PORT_DIR (dir_in of the next stage).
- credit_out  output  1  one-cycle pulse per slot freed, sent upstream.
- occupancy  output  PTR_W+1  current number of stored flits, 0..DEPTH.
- overflow_err  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all of the following hold, independent of clk:
  - rd_ptr=0, wr_ptr=0, count=0.
  - flit_out=0, flit_valid_out=0, credit_out=0, overflow_err=0.
  - Buffer contents are discarded.
- Reset asserted mid-operation drops all stored flits. No credits are returned for them; the upstream credit counter is reset by the same rst.
- dir_out is tied to PORT_DIR at all times, including during reset.
- Internal signals:
  - empty = (count==0); full = (count==DEPTH).
  - pop = ~empty & ~stall.
  - push = flit_in_valid & (~full | pop).
- On push: mem[wr_ptr] <= flit_in; wr_ptr increments modulo DEPTH, wrapping naturally in PTR_W bits. The flit is stored unmodified; the in-band bit at ValidBitPos is not inspected.
- On pop:
  - flit_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - flit_valid_out <= 1 and credit_out <= 1 on the next edge.
- When there is no pop: flit_valid_out <= 0 and credit_out <= 0; flit_out holds its last value.
- count update: push only +1; pop only -1; both or neither unchanged. occupancy = count.
- Latency: a flit written at edge t is first poppable at edge t+1 and appears on flit_out with flit_valid_out=1 after edge t+1. Minimum 2 cycles input to output, with no bypass path.
- Throughput: one flit per cycle sustained when stall=0.
- Full and flit_in_valid=1 with pop in the same cycle: the write is accepted into the slot being freed (wr_ptr==rd_ptr). The read returns the old data, and count stays DEPTH.
- Full and flit_in_valid=1 without pop: the flit is dropped, overflow_err <= 1 (sticky until rst), and state is otherwise unchanged. With a correct credit protocol this cannot occur.
- stall=1 blocks pop only; pushes continue.
- Stall while empty has no effect.
- flit_valid_out is never high for two cycles with the same payload.
- Flits leave in arrival order. Head, body and tail flits are treated identically; no packet awareness.
- Total credits pulsed equals total flits popped since reset.

Test Plan:
- Reset: hold rst=1 mid-stream with 3 flits stored, asynchronously between edges → outputs immediately 0, occupancy=0; after release, no flits emerge and no credit pulses occur.
- Single flit: push flit_in=85'h1_2345_6789_ABCD_EF01_2345 at edge 0 with stall=0 → flit_out equals it with flit_valid_out=1 after edge 1, credit_out=1 after edge 1 for one cycle; dir_out=PORT_DIR throughout.
- Streaming: push 20 consecutive incrementing flits with stall=0 → 20 outputs in order, one per cycle, 2-cycle latency, occupancy never exceeds 1, 20 credit pulses.
- Fill and stall: stall=1, push 8 flits → occupancy=8, no valid_out; push a 9th → dropped, overflow_err=1; release stall → exactly flits 1..8 out on 8 consecutive cycles.
- Full with simultaneous push/pop: fill to 8, stall=0, push flit 9 on the first pop cycle → accepted, occupancy stays 8, output order 1..9, overflow_err remains 0.
- Pointer wrap: alternate stall patterns over 50 pushes with DEPTH=8 → order preserved across multiple wraps, and credits equal pops.
